flow_led_seq: RTL and testbench
===============================

Name: flow_led_seq

Overview:
Parametrised LED pattern sequencer. It generalises the fixed 4-LED rotator to LED_NUM outputs, run-time step period, four motion modes and output polarity. It sits between the board clock and the LED pins. It is driven by static configuration inputs (switches or a control register), with no handshake partner.

Parameters:
LED_NUM, 4, number of LEDs; legal range 2..32
CNT_W, 25, prescaler counter width in bits
DEF_PERIOD, 8_000_000, step period in clock cycles used from reset until the first wrap
INIT_POS, 2, LED index lit at reset; must be less than LED_NUM
LED_ACTIVE_LOW, 0, 1 inverts the led output bus

Ports:
sys_clk   in   1         system clock; all logic on its rising edge
rst       in   1         synchronous reset, active-high
en        in   1         1 = prescaler runs; 0 = counter, pattern and outputs hold
mode      in   2         00 rotate-up, 01 rotate-down, 10 bounce, 11 bar-fill
period_i  in   CNT_W     step period in cycles; sampled only at prescaler wrap
led       out  LED_NUM   registered LED drive
step_o    out  1         registered one-cycle pulse, coincident with each led update
dir_o     out  1         registered bounce direction (1 = up, toward MSB)

Behaviour:
- Reset: rst is sampled only on the sys_clk edge. rst high overrides all other inputs, including mid-count and mid-bounce.
- Reset values: cnt = 0; per_reg = DEF_PERIOD; pos = INIT_POS; dir_o = 1; step_o = 0; led = onehot(INIT_POS), XOR all-ones if LED_ACTIVE_LOW.
- Effective period: P = max(per_reg, 1). per_reg = 0 means step every cycle.
- Prescaler:
  - en = 1 and cnt != P-1: cnt <= cnt + 1; step_o <= 0.
  - en = 1 and cnt == P-1 (wrap): cnt <= 0; per_reg <= period_i; step_o <= 1; pos, dir_o and led update on this same edge.
  - en = 0: cnt, per_reg, pos, dir_o and led hold; step_o <= 0. When en returns, counting resumes from the held cnt.
- Step timing: led changes exactly every P enabled cycles. The first change occurs DEF_PERIOD enabled cycles after rst release.
- Period changes: a change on period_i mid-interval has no effect until the next wrap. The new value then governs the following interval.
- Mode is sampled at each wrap; a change takes effect on the next step. pos and dir_o carry over across mode changes. No re-initialisation.
- Mode 00, rotate-up: pos <= (pos == LED_NUM-1) ? 0 : pos + 1.
- Mode 01, rotate-down: pos <= (pos == 0) ? LED_NUM-1 : pos - 1.
- Mode 10, bounce:
  - Move pos one step in dir_o.
  - At pos == LED_NUM-1 with dir_o = 1: pos <= LED_NUM-2, dir_o <= 0.
  - At pos == 0 with dir_o = 0: pos <= 1, dir_o <= 1.
  - No dwell at the ends. For LED_NUM = 4 from pos 0: 0,1,2,3,2,1,0,1...
- Mode 11, bar-fill: pos increments with wrap as in mode 00. Pattern = bits 0..pos set.
- dir_o changes only in mode 10; it holds in all other modes.
- Pattern decode: modes 00/01/10 give onehot(new pos); mode 11 gives the thermometer code of new pos. led <= pattern, inverted when LED_ACTIVE_LOW = 1.
- led is updated only on step edges. Between steps it holds.
- Widths: pos is max(1, clog2(LED_NUM)) bits. cnt is CNT_W bits. P-1 is computed in CNT_W bits, and the max(...,1) guard prevents underflow.

Test Plan:
1. LED_NUM=4, DEF_PERIOD=3, period_i=3, mode=00, en=1, release rst → led=0100; step_o pulses every 3 cycles; led sequence 1000, 0001, 0010, 0100.
2. Same setup, mode=10 → led 1000, 0100, 0010, 0001, 0010, 0100; dir_o goes to 0 on the 1000→0100 step and to 1 on the 0001→0010 step.
3. Same setup, mode=11 from reset → led 1111, 0001, 0011, 0111, 1111; mode switched to 01 mid-interval → reversal applies only from the next step_o.
4. Rotate-up running, en low for 10 cycles when cnt=1 → led, dir_o and cnt frozen, step_o=0; after en returns, next step occurs 2 enabled cycles later.
5. period_i changed 3→0 mid-interval → current interval still 3 cycles, then step_o high every cycle with led advancing each cycle; period_i=5 → 5-cycle spacing after the next wrap.
6. LED_ACTIVE_LOW=1 → reset led=1011; assert rst one cycle mid-bounce with dir_o=0 → next edge led=1011, dir_o=1, step_o=0, and the count restarts at DEF_PERIOD.

Source files
------------

// File: rtl/flow_led_seq.sv
// flow_led_seq: parametrised LED pattern sequencer with prescaled stepping.
// Rotate-up, rotate-down, bounce and bar-fill motion; optional active-low drive.
module flow_led_seq #(
  parameter int LED_NUM        = 4,
  parameter int CNT_W          = 25,
  parameter int DEF_PERIOD     = 8_000_000,
  parameter int INIT_POS       = 2,
  parameter int LED_ACTIVE_LOW = 0
) (
  input  logic               sys_clk,
  input  logic               rst,
  input  logic               en,
  input  logic [1:0]         mode,
  input  logic [CNT_W-1:0]   period_i,
  output logic [LED_NUM-1:0] led,
  output logic               step_o,
  output logic               dir_o
);

  localparam int PW = ($clog2(LED_NUM) > 1) ? $clog2(LED_NUM) : 1;

  localparam logic [PW-1:0]      LAST = PW'(LED_NUM - 1);
  localparam logic [PW-1:0]      POS0 = PW'(INIT_POS);
  localparam logic [PW-1:0]      ONEP = PW'(1);
  localparam logic [LED_NUM-1:0] ONE  = LED_NUM'(1);
  localparam logic [LED_NUM-1:0] INV  =
    (LED_ACTIVE_LOW != 0) ? {LED_NUM{1'b1}} : {LED_NUM{1'b0}};
  localparam logic [LED_NUM-1:0] LED0 = (ONE << POS0) ^ INV;
  localparam logic [CNT_W-1:0]   PER0 = CNT_W'(DEF_PERIOD);
  localparam logic [CNT_W-1:0]   ONEC = CNT_W'(1);

  typedef enum logic [1:0] {
    M_UP     = 2'b00,
    M_DOWN   = 2'b01,
    M_BOUNCE = 2'b10,
    M_BAR    = 2'b11
  } mode_e;

  mode_e mode_s;
  assign mode_s = mode_e'(mode);

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   per_q, per_d;
  logic [PW-1:0]      pos_q, pos_d;
  logic               dir_q, dir_d;
  logic [LED_NUM-1:0] led_q, led_d;
  logic               step_q, step_d;

  logic [CNT_W-1:0]   p_last;
  logic               wrap;
  logic [PW-1:0]      nxt_pos;
  logic               nxt_dir;
  logic [LED_NUM-1:0] pat;

  // zero period behaves as one so P-1 never underflows
  always_comb begin
    p_last = (per_q == '0) ? '0 : per_q - ONEC;
    wrap   = en && (cnt_q == p_last);
  end

  always_comb begin
    nxt_pos = pos_q;
    nxt_dir = dir_q;
    unique case (mode_s)
      M_UP, M_BAR: begin
        nxt_pos = (pos_q == LAST) ? '0 : pos_q + ONEP;
      end
      M_DOWN: begin
        nxt_pos = (pos_q == '0) ? LAST : pos_q - ONEP;
      end
      M_BOUNCE: begin
        if (dir_q && (pos_q == LAST)) begin
          nxt_pos = LAST - ONEP;
          nxt_dir = 1'b0;
        end else if (!dir_q && (pos_q == '0)) begin
          nxt_pos = ONEP;
          nxt_dir = 1'b1;
        end else if (dir_q) begin
          nxt_pos = pos_q + ONEP;
        end else begin
          nxt_pos = pos_q - ONEP;
        end
      end
    endcase
  end

  always_comb begin
    pat = ONE << nxt_pos;
    if (mode_s == M_BAR) begin
      for (int i = 0; i < LED_NUM; i++) begin
        pat[i] = (i <= int'(nxt_pos));
      end
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    per_d  = per_q;
    pos_d  = pos_q;
    dir_d  = dir_q;
    led_d  = led_q;
    step_d = 1'b0;
    if (wrap) begin
      cnt_d  = '0;
      per_d  = period_i;
      pos_d  = nxt_pos;
      dir_d  = nxt_dir;
      led_d  = pat ^ INV;
      step_d = 1'b1;
    end else if (en) begin
      cnt_d  = cnt_q + ONEC;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      cnt_q  <= '0;
      per_q  <= PER0;
      pos_q  <= POS0;
      dir_q  <= 1'b1;
      led_q  <= LED0;
      step_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      per_q  <= per_d;
      pos_q  <= pos_d;
      dir_q  <= dir_d;
      led_q  <= led_d;
      step_q <= step_d;
    end
  end

  assign led    = led_q;
  assign step_o = step_q;
  assign dir_o  = dir_q;

endmodule

// File: tb/tb_flow_led_seq.sv
// tb_flow_led_seq: directed checks of flow_led_seq.
// Two instances share stimulus: active-high and active-low drive.
module tb_flow_led_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic [7:0] period_i;
  logic [3:0] led0, led1;
  logic       step0, step1;
  logic       dir0, dir1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  flow_led_seq #(
    .LED_NUM(4), .CNT_W(8), .DEF_PERIOD(3),
    .INIT_POS(2), .LED_ACTIVE_LOW(0)
  ) u_hi (
    .sys_clk(clk), .rst(rst), .en(en), .mode(mode),
    .period_i(period_i), .led(led0), .step_o(step0), .dir_o(dir0)
  );

  flow_led_seq #(
    .LED_NUM(4), .CNT_W(8), .DEF_PERIOD(3),
    .INIT_POS(2), .LED_ACTIVE_LOW(1)
  ) u_lo (
    .sys_clk(clk), .rst(rst), .en(en), .mode(mode),
    .period_i(period_i), .led(led1), .step_o(step1), .dir_o(dir1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [1:0] m);
    rst = 1'b1;
    en = 1'b1;
    mode = m;
    period_i = 8'd3;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(2'b00);
    checks++;
    if (led0 !== 4'b0100) begin
      errors++;
      $display("FAIL reset_led got %b exp 0100", led0);
    end
    checks++;
    if (led1 !== 4'b1011) begin
      errors++;
      $display("FAIL reset_led_n got %b exp 1011", led1);
    end
    checks++;
    if (step0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_step got %b exp 0", step0);
    end
    checks++;
    if (dir0 !== 1'b1) begin
      errors++;
      $display("FAIL reset_dir got %b exp 1", dir0);
    end
  endtask

  task automatic test_rotate_up();
    logic [3:0] exp [4];
    logic [3:0] prev;
    exp = '{4'b1000, 4'b0001, 4'b0010, 4'b0100};
    do_reset(2'b00);
    prev = 4'b0100;
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 2; c++) begin
        tick();
        checks++;
        if (step0 !== 1'b0 || led0 !== prev) begin
          errors++;
          $display("FAIL rot_hold k=%0d got step=%b led=%b exp 0 %b",
                   k, step0, led0, prev);
        end
      end
      tick();
      checks++;
      if (step0 !== 1'b1 || led0 !== exp[k]) begin
        errors++;
        $display("FAIL rot_step k=%0d got step=%b led=%b exp 1 %b",
                 k, step0, led0, exp[k]);
      end
      prev = exp[k];
    end
  endtask

  task automatic test_bounce();
    logic [3:0] exp [6];
    logic       expd [6];
    exp  = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010, 4'b0100};
    expd = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    do_reset(2'b10);
    for (int k = 0; k < 6; k++) begin
      tick();
      tick();
      tick();
      checks++;
      if (step0 !== 1'b1 || led0 !== exp[k] || dir0 !== expd[k]) begin
        errors++;
        $display("FAIL bounce k=%0d got s=%b l=%b d=%b exp 1 %b %b",
                 k, step0, led0, dir0, exp[k], expd[k]);
      end
      checks++;
      if (led1 !== ~exp[k]) begin
        errors++;
        $display("FAIL bounce_n k=%0d got %b exp %b", k, led1, ~exp[k]);
      end
    end
  endtask

  task automatic test_bar_switch();
    logic [3:0] exp [5];
    exp = '{4'b1111, 4'b0001, 4'b0011, 4'b0111, 4'b1111};
    do_reset(2'b11);
    for (int k = 0; k < 5; k++) begin
      tick();
      tick();
      tick();
      checks++;
      if (step0 !== 1'b1 || led0 !== exp[k]) begin
        errors++;
        $display("FAIL bar k=%0d got s=%b l=%b exp 1 %b",
                 k, step0, led0, exp[k]);
      end
    end
    tick();
    mode = 2'b01;
    tick();
    checks++;
    if (step0 !== 1'b0 || led0 !== 4'b1111) begin
      errors++;
      $display("FAIL sw_hold got s=%b l=%b exp 0 1111", step0, led0);
    end
    tick();
    checks++;
    if (step0 !== 1'b1 || led0 !== 4'b0100) begin
      errors++;
      $display("FAIL sw_down1 got s=%b l=%b exp 1 0100", step0, led0);
    end
    tick();
    tick();
    tick();
    checks++;
    if (step0 !== 1'b1 || led0 !== 4'b0010) begin
      errors++;
      $display("FAIL sw_down2 got s=%b l=%b exp 1 0010", step0, led0);
    end
  endtask

  task automatic test_enable_hold();
    do_reset(2'b00);
    tick();
    en = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if (step0 !== 1'b0 || led0 !== 4'b0100 || dir0 !== 1'b1) begin
        errors++;
        $display("FAIL en_hold c=%0d got s=%b l=%b d=%b exp 0 0100 1",
                 c, step0, led0, dir0);
      end
    end
    en = 1'b1;
    tick();
    checks++;
    if (step0 !== 1'b0 || led0 !== 4'b0100) begin
      errors++;
      $display("FAIL en_resume1 got s=%b l=%b exp 0 0100", step0, led0);
    end
    tick();
    checks++;
    if (step0 !== 1'b1 || led0 !== 4'b1000) begin
      errors++;
      $display("FAIL en_resume2 got s=%b l=%b exp 1 1000", step0, led0);
    end
  endtask

  task automatic test_period_change();
    logic [3:0] exp [4];
    exp = '{4'b1000, 4'b0001, 4'b0010, 4'b0100};
    do_reset(2'b00);
    tick();
    period_i = 8'd0;
    tick();
    checks++;
    if (step0 !== 1'b0) begin
      errors++;
      $display("FAIL per_old got s=%b exp 0", step0);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (step0 !== 1'b1 || led0 !== exp[k]) begin
        errors++;
        $display("FAIL per_fast k=%0d got s=%b l=%b exp 1 %b",
                 k, step0, led0, exp[k]);
      end
    end
    period_i = 8'd5;
    tick();
    checks++;
    if (step0 !== 1'b1 || led0 !== 4'b1000) begin
      errors++;
      $display("FAIL per_load got s=%b l=%b exp 1 1000", step0, led0);
    end
    period_i = 8'd3;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (step0 !== 1'b0 || led0 !== 4'b1000) begin
        errors++;
        $display("FAIL per5_hold c=%0d got s=%b l=%b exp 0 1000",
                 c, step0, led0);
      end
    end
    tick();
    checks++;
    if (step0 !== 1'b1 || led0 !== 4'b0001) begin
      errors++;
      $display("FAIL per5_step got s=%b l=%b exp 1 0001", step0, led0);
    end
  endtask

  task automatic test_reset_mid_bounce();
    do_reset(2'b10);
    for (int c = 0; c < 6; c++) tick();
    checks++;
    if (dir0 !== 1'b0 || led1 !== 4'b1011) begin
      errors++;
      $display("FAIL mid_pre got d=%b ln=%b exp 0 1011", dir0, led1);
    end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (led1 !== 4'b1011 || dir1 !== 1'b1 || step1 !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst got ln=%b d=%b s=%b exp 1011 1 0",
               led1, dir1, step1);
    end
    tick();
    tick();
    checks++;
    if (step1 !== 1'b0 || led1 !== 4'b1011) begin
      errors++;
      $display("FAIL mid_cnt got s=%b ln=%b exp 0 1011", step1, led1);
    end
    tick();
    checks++;
    if (step1 !== 1'b1 || led1 !== 4'b0111 || led0 !== 4'b1000) begin
      errors++;
      $display("FAIL mid_step got s=%b ln=%b l=%b exp 1 0111 1000",
               step1, led1, led0);
    end
  endtask

  initial begin
    rst = 1'b1;
    en = 1'b1;
    mode = 2'b00;
    period_i = 8'd3;
    test_reset();
    test_rotate_up();
    test_bounce();
    test_bar_switch();
    test_enable_hold();
    test_period_change();
    test_reset_mid_bounce();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
